pipeline_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline.
- Generates per-register enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC write enable.
- Resolves data-memory wait, instruction-fetch wait, load-use hazards, taken branches/jumps and halt.
- Tracks a branch redirect that arrives during a memory freeze and counts stall cycles.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-number fields, pipeline controller state and
// the packed bundle of pipe-register enables/flushes.
package cpu_types_pkg;

  localparam int REG_BITS = 5;

  typedef logic [REG_BITS-1:0] regbits_t;

  typedef enum logic {
    PC_RUN    = 1'b0,
    PC_HALTED = 1'b1
  } pctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pctrl_out_t;

  // Field order: pc_en, en[IF/ID..MEM/WB], flush[IF/ID..MEM/WB]
  localparam pctrl_out_t PCTRL_ADVANCE = 9'b1_1111_0000;
  localparam pctrl_out_t PCTRL_RESET   = 9'b0_0000_1111;
  localparam pctrl_out_t PCTRL_FROZEN  = 9'b0_0000_0000;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in ID/EX whose destination feeds the
// instruction in IF/ID. Register 0 is hard-wired and never creates a hazard.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_dest,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             lu_stall
);

  assign lu_stall = ex_dREN && (ex_dest != '0) &&
                    ((ex_dest == id_rs) || (ex_dest == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: priority mux of
// halt, data wait, redirect, load-use and fetch wait, plus a saturating stall counter.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_dest,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_br_taken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  pctrl_state_t     state_q, state_d;
  logic             br_pend_q, br_pend_d;
  logic             halt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             lu_stall;
  logic             dwait;
  pctrl_out_t       ctl;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_dREN  (ex_dREN),
    .ex_dest  (ex_dest),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .lu_stall (lu_stall)
  );

  assign dwait = (mem_dREN | mem_dWEN) & ~dhit;

  always_comb begin
    ctl       = PCTRL_ADVANCE;
    state_d   = state_q;
    br_pend_d = br_pend_q;
    if (RST) begin
      ctl = PCTRL_RESET;
    end else if (state_q == PC_HALTED || wb_halt) begin
      ctl     = PCTRL_FROZEN;
      state_d = PC_HALTED;
    end else if (dwait) begin
      // EX is frozen, so a redirect seen again during the freeze is the same branch
      ctl.pc_en       = 1'b0;
      ctl.ifid_en     = 1'b0;
      ctl.idex_en     = 1'b0;
      ctl.exmem_en    = 1'b0;
      ctl.memwb_flush = 1'b1;
      br_pend_d       = br_pend_q | ex_br_taken;
    end else if (ex_br_taken || br_pend_q) begin
      ctl.ifid_flush = 1'b1;
      ctl.idex_flush = 1'b1;
      br_pend_d      = 1'b0;
    end else if (lu_stall) begin
      ctl.pc_en      = 1'b0;
      ctl.ifid_en    = 1'b0;
      ctl.idex_flush = 1'b1;
    end else if (!ihit) begin
      ctl.pc_en      = 1'b0;
      ctl.ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= PC_RUN;
      br_pend_q   <= 1'b0;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
      halt_q    <= (state_d == PC_HALTED);
      if (state_q == PC_RUN && !ctl.pc_en && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign idex_en     = ctl.idex_en;
  assign exmem_en    = ctl.exmem_en;
  assign memwb_en    = ctl.memwb_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign memwb_flush = ctl.memwb_flush;
  assign halt        = halt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a 32-bit counter instance plus a 2-bit counter
// instance fed the same stimulus so counter saturation is reached quickly.
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_br_taken, wb_halt;
  logic [4:0] ex_dest, id_rs, id_rt;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [31:0] stall_cnt;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halt;
  logic [1:0]  s_cnt;

  logic [8:0] ctl_vec;
  assign ctl_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};

  // Expected control vectors: {pc_en, en IF/ID..MEM/WB, flush IF/ID..MEM/WB}
  localparam logic [8:0] C_RST = 9'b0_0000_1111;
  localparam logic [8:0] C_NRM = 9'b1_1111_0000;
  localparam logic [8:0] C_HLT = 9'b0_0000_0000;
  localparam logic [8:0] C_DW  = 9'b0_0001_0001;
  localparam logic [8:0] C_BR  = 9'b1_1111_1100;
  localparam logic [8:0] C_LU  = 9'b0_0111_0100;
  localparam logic [8:0] C_FW  = 9'b0_1111_1000;

  typedef struct {
    logic       rst, ih, dh, mr, mw, er;
    logic [4:0] ed, rs, rt;
    logic       br, wh;
    logic [8:0] ctl;
    logic       hlt;
    logic [31:0] cnt;
    logic [1:0] sat;
  } row_t;

  typedef struct {
    logic [8:0]  ctl;
    logic        hlt;
    logic [31:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  pipeline_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN), .ex_dest(ex_dest), .id_rs(id_rs),
    .id_rt(id_rt), .ex_br_taken(ex_br_taken), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN), .ex_dest(ex_dest), .id_rs(id_rs),
    .id_rt(id_rt), .ex_br_taken(ex_br_taken), .wb_halt(wb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .halt(s_halt),
    .stall_cnt(s_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic row_t mk(input int rst, ih, dh, mr, mw, er, ed, rs, rt,
                              br, wh, ctl, hlt, cnt, sat);
    row_t r;
    r.rst = 1'(rst); r.ih = 1'(ih); r.dh = 1'(dh); r.mr = 1'(mr); r.mw = 1'(mw);
    r.er = 1'(er); r.ed = 5'(ed); r.rs = 5'(rs); r.rt = 5'(rt);
    r.br = 1'(br); r.wh = 1'(wh); r.ctl = 9'(ctl); r.hlt = 1'(hlt);
    r.cnt = 32'(cnt); r.sat = 2'(sat);
    return r;
  endfunction

  // Drive one row at the negedge and record its expectation in the scoreboard
  task automatic apply(input row_t r);
    exp_t e;
    @(negedge CLK);
    RST = r.rst; ihit = r.ih; dhit = r.dh; mem_dREN = r.mr; mem_dWEN = r.mw;
    ex_dREN = r.er; ex_dest = r.ed; id_rs = r.rs; id_rt = r.rt;
    ex_br_taken = r.br; wb_halt = r.wh;
    e.ctl = r.ctl; e.hlt = r.hlt; e.cnt = r.cnt; e.sat = r.sat;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    row_t r[$]; exp_t e; logic [8:0] g;
    r.push_back(mk(1,1,1,0,0,0,0,0,0,0,0, C_RST,0,0,0));
    r.push_back(mk(1,0,0,1,0,1,8,8,8,1,1, C_RST,0,0,0));
    r.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, C_NRM,0,0,0));
    foreach (r[i]) begin
      apply(r[i]); #2 g = ctl_vec; @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++;
      if ({g, halt, stall_cnt, s_cnt} !== {e.ctl, e.hlt, e.cnt, e.sat})
        $display("FAIL reset[%0d] got ctl=%b halt=%b cnt=%0d sat=%0d want ctl=%b halt=%b cnt=%0d sat=%0d",
                 i, g, halt, stall_cnt, s_cnt, e.ctl, e.hlt, e.cnt, e.sat);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    row_t r[$]; exp_t e; logic [8:0] g;
    r.push_back(mk(0,1,1,0,0,1,8,3,8,0,0, C_LU, 0,1,1));
    r.push_back(mk(0,1,1,0,0,0,8,3,8,0,0, C_NRM,0,1,1));
    r.push_back(mk(0,1,1,0,0,1,0,0,0,0,0, C_NRM,0,1,1));
    r.push_back(mk(0,1,1,0,0,1,5,5,9,0,0, C_LU, 0,2,2));
    r.push_back(mk(0,1,1,0,0,1,5,6,7,0,0, C_NRM,0,2,2));
    r.push_back(mk(0,1,1,0,0,0,5,5,5,0,0, C_NRM,0,2,2));
    foreach (r[i]) begin
      apply(r[i]); #2 g = ctl_vec; @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++;
      if ({g, halt, stall_cnt, s_cnt} !== {e.ctl, e.hlt, e.cnt, e.sat})
        $display("FAIL load_use[%0d] got ctl=%b halt=%b cnt=%0d sat=%0d want ctl=%b halt=%b cnt=%0d sat=%0d",
                 i, g, halt, stall_cnt, s_cnt, e.ctl, e.hlt, e.cnt, e.sat);
      else n_pass++;
    end
  endtask

  task automatic test_mem_branch();
    row_t r[$]; exp_t e; logic [8:0] g;
    r.push_back(mk(0,1,0,1,0,0,0,0,0,1,0, C_DW, 0,3,3));
    r.push_back(mk(0,1,0,1,0,0,0,0,0,0,0, C_DW, 0,4,3));
    r.push_back(mk(0,0,0,1,0,0,0,0,0,0,0, C_DW, 0,5,3));
    r.push_back(mk(0,1,1,1,0,0,0,0,0,0,0, C_BR, 0,5,3));
    r.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, C_NRM,0,5,3));
    r.push_back(mk(0,0,1,0,0,0,0,0,0,1,0, C_BR, 0,5,3));
    foreach (r[i]) begin
      apply(r[i]); #2 g = ctl_vec; @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++;
      if ({g, halt, stall_cnt, s_cnt} !== {e.ctl, e.hlt, e.cnt, e.sat})
        $display("FAIL mem_branch[%0d] got ctl=%b halt=%b cnt=%0d sat=%0d want ctl=%b halt=%b cnt=%0d sat=%0d",
                 i, g, halt, stall_cnt, s_cnt, e.ctl, e.hlt, e.cnt, e.sat);
      else n_pass++;
    end
  endtask

  task automatic test_fetch_wait();
    row_t r[$]; exp_t e; logic [8:0] g;
    r.push_back(mk(0,0,1,0,0,0,0,0,0,0,0, C_FW, 0,6,3));
    r.push_back(mk(0,0,1,0,0,0,0,0,0,0,0, C_FW, 0,7,3));
    r.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, C_NRM,0,7,3));
    foreach (r[i]) begin
      apply(r[i]); #2 g = ctl_vec; @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++;
      if ({g, halt, stall_cnt, s_cnt} !== {e.ctl, e.hlt, e.cnt, e.sat})
        $display("FAIL fetch_wait[%0d] got ctl=%b halt=%b cnt=%0d sat=%0d want ctl=%b halt=%b cnt=%0d sat=%0d",
                 i, g, halt, stall_cnt, s_cnt, e.ctl, e.hlt, e.cnt, e.sat);
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    row_t r[$]; exp_t e; logic [8:0] g;
    r.push_back(mk(0,0,0,1,0,1,8,8,0,0,0, C_DW, 0,8,3));
    r.push_back(mk(0,1,1,1,0,0,0,0,0,0,0, C_NRM,0,8,3));
    r.push_back(mk(0,1,1,0,0,1,8,8,0,1,0, C_BR, 0,8,3));
    r.push_back(mk(0,0,1,0,0,1,8,0,8,0,0, C_LU, 0,9,3));
    r.push_back(mk(0,1,0,0,1,0,0,0,0,0,0, C_DW, 0,10,3));
    r.push_back(mk(0,1,1,0,1,0,0,0,0,0,0, C_NRM,0,10,3));
    foreach (r[i]) begin
      apply(r[i]); #2 g = ctl_vec; @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++;
      if ({g, halt, stall_cnt, s_cnt} !== {e.ctl, e.hlt, e.cnt, e.sat})
        $display("FAIL priority[%0d] got ctl=%b halt=%b cnt=%0d sat=%0d want ctl=%b halt=%b cnt=%0d sat=%0d",
                 i, g, halt, stall_cnt, s_cnt, e.ctl, e.hlt, e.cnt, e.sat);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    row_t r[$]; exp_t e; logic [8:0] g;
    r.push_back(mk(0,1,1,0,0,0,0,0,0,0,1, C_HLT,1,11,3));
    r.push_back(mk(0,0,0,1,0,1,8,8,0,1,0, C_HLT,1,11,3));
    r.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, C_HLT,1,11,3));
    r.push_back(mk(0,0,1,0,0,0,0,0,0,0,0, C_HLT,1,11,3));
    foreach (r[i]) begin
      apply(r[i]); #2 g = ctl_vec; @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++;
      if ({g, halt, stall_cnt, s_cnt} !== {e.ctl, e.hlt, e.cnt, e.sat})
        $display("FAIL halt[%0d] got ctl=%b halt=%b cnt=%0d sat=%0d want ctl=%b halt=%b cnt=%0d sat=%0d",
                 i, g, halt, stall_cnt, s_cnt, e.ctl, e.hlt, e.cnt, e.sat);
      else n_pass++;
    end
  endtask

  task automatic test_reset_freeze();
    row_t r[$]; exp_t e; logic [8:0] g;
    r.push_back(mk(1,1,1,0,0,0,0,0,0,0,0, C_RST,0,0,0));
    r.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, C_NRM,0,0,0));
    r.push_back(mk(0,1,0,1,0,0,0,0,0,1,0, C_DW, 0,1,1));
    r.push_back(mk(0,1,0,1,0,0,0,0,0,1,0, C_DW, 0,2,2));
    r.push_back(mk(0,1,1,1,0,0,0,0,0,0,0, C_BR, 0,2,2));
    r.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, C_NRM,0,2,2));
    r.push_back(mk(0,1,0,1,0,0,0,0,0,1,0, C_DW, 0,3,3));
    r.push_back(mk(1,1,0,1,0,0,0,0,0,0,0, C_RST,0,0,0));
    r.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, C_NRM,0,0,0));
    foreach (r[i]) begin
      apply(r[i]); #2 g = ctl_vec; @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++;
      if ({g, halt, stall_cnt, s_cnt} !== {e.ctl, e.hlt, e.cnt, e.sat})
        $display("FAIL reset_freeze[%0d] got ctl=%b halt=%b cnt=%0d sat=%0d want ctl=%b halt=%b cnt=%0d sat=%0d",
                 i, g, halt, stall_cnt, s_cnt, e.ctl, e.hlt, e.cnt, e.sat);
      else n_pass++;
    end
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    ex_dREN = 1'b0; ex_dest = '0; id_rs = '0; id_rt = '0;
    ex_br_taken = 1'b0; wb_halt = 1'b0;
    test_reset();
    test_load_use();
    test_mem_branch();
    test_fetch_wait();
    test_priority();
    test_halt();
    test_reset_freeze();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
